sort_scheduler: RTL and testbench

SORT_SCHEDULER -- requirements
Module: sort_scheduler

---
 rtl/sort_scheduler_if.sv | 23 ++
 rtl/sort_scheduler.sv | 85 ++++++++
 tb/tb_sort_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sort_scheduler_if.sv
// sort_scheduler_if: frame, sorter handshake and published-order bus around the scheduler
interface sort_scheduler_if;
  logic        i_enable;
  logic        i_frame_done;
  logic        o_sort_start;
  logic        i_sort_done;
  logic [63:0] i_sort_order;
  logic [63:0] o_order;
  logic        o_order_valid;
  logic        o_stable;
  logic        o_busy;
  logic        o_timeout;
  logic        i_clr_err;
  logic [7:0]  o_drop_cnt;
  modport slave (
    input  i_enable, i_frame_done, i_sort_done, i_sort_order, i_clr_err,
    output o_sort_start, o_order, o_order_valid, o_stable, o_busy, o_timeout, o_drop_cnt
  );
  modport master (
    output i_enable, i_frame_done, i_sort_done, i_sort_order, i_clr_err,
    input  o_sort_start, o_order, o_order_valid, o_stable, o_busy, o_timeout, o_drop_cnt
  );
endinterface

// File: rtl/sort_scheduler.sv
// sort_scheduler: launches the sorter per frame and publishes an order once it repeats STABLE_CNT times
module sort_scheduler #(
  parameter int STABLE_CNT = 3,
  parameter int TIMEOUT    = 63
) (
  input logic             i_clk,
  input logic             i_rst_n,
  sort_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, CHECK} state_t;
  localparam logic [2:0] STB     = 3'(STABLE_CNT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t      state_q;
  logic [7:0]  wait_cnt_q, drop_q;
  logic [2:0]  match_q, match_d;
  logic [63:0] cand_q, prev_q, order_q;
  logic        sort_start_q, order_valid_q, stable_q, busy_q, timeout_q, timeout_hit;
  assign timeout_hit = state_q == WAIT && !bus.i_sort_done && wait_cnt_q == TO_LAST;
  assign match_d = state_q == CHECK ? (cand_q != prev_q ? 3'd1 : match_q == STB ? STB : match_q + 3'd1)
                 : timeout_hit ? 3'd0 : match_q;
  // scheduler FSM with all outputs, counters and result registers held in flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      drop_q        <= '0;
      match_q       <= '0;
      cand_q        <= '0;
      prev_q        <= '0;
      order_q       <= '0;
      sort_start_q  <= 1'b0;
      order_valid_q <= 1'b0;
      stable_q      <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      sort_start_q  <= 1'b0;
      order_valid_q <= 1'b0;
      match_q       <= match_d;
      stable_q      <= match_d == STB;
      if (bus.i_frame_done && (state_q != IDLE || !bus.i_enable) && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
      if (bus.i_clr_err)
        timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.i_frame_done && bus.i_enable) begin
          state_q      <= START;
          sort_start_q <= 1'b1;
          busy_q       <= 1'b1;
        end
        START: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: if (bus.i_sort_done) begin
          cand_q  <= bus.i_sort_order;
          state_q <= CHECK;
        end else if (timeout_hit) begin
          timeout_q <= 1'b1;
          state_q   <= IDLE;
          busy_q    <= 1'b0;
        end else begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
        end
        CHECK: begin
          prev_q  <= cand_q;
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (match_d == STB && cand_q != order_q) begin
            order_q       <= cand_q;
            order_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.o_sort_start  = sort_start_q;
  assign bus.o_order       = order_q;
  assign bus.o_order_valid = order_valid_q;
  assign bus.o_stable      = stable_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_timeout     = timeout_q;
  assign bus.o_drop_cnt    = drop_q;
endmodule

// File: tb/tb_sort_scheduler.sv
// tb_sort_scheduler: directed scenarios with a publish scoreboard for sort_scheduler
module tb_sort_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int pub_cnt = 0;
  int p0;
  logic [63:0] sb[$];
  logic [63:0] exp_pub;
  localparam logic [63:0] X = 64'h0123456789ABCDEF;
  localparam logic [63:0] A = 64'hAAAA_1111_2222_3333;
  localparam logic [63:0] B = 64'h5555_4444_6666_7777;
  localparam logic [63:0] C = 64'hC0C0_C1C1_C2C2_C3C3;
  localparam logic [63:0] D = 64'hDEAD_BEEF_0BAD_F00D;
  sort_scheduler_if bus ();
  sort_scheduler #(.STABLE_CNT(3), .TIMEOUT(63)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // every publish must match the oldest expected order
  always @(negedge clk) begin
    if (bus.o_order_valid) begin
      pub_cnt++;
      if (sb.size() != 0) exp_pub = sb.pop_front();
      else exp_pub = 'x;
      chk("publish", bus.o_order, exp_pub);
    end
  end
  task automatic check_reset(input string tag);
    chk({tag, "_start"}, bus.o_sort_start, 1'b0);
    chk({tag, "_valid"}, bus.o_order_valid, 1'b0);
    chk({tag, "_stable"}, bus.o_stable, 1'b0);
    chk({tag, "_busy"}, bus.o_busy, 1'b0);
    chk({tag, "_timeout"}, bus.o_timeout, 1'b0);
    chk({tag, "_order"}, bus.o_order, 64'h0);
    chk({tag, "_drop"}, bus.o_drop_cnt, 8'h0);
    chk({tag, "_state"}, dut.state_q, 2'd0);
    chk({tag, "_wcnt"}, dut.wait_cnt_q, 8'h0);
    chk({tag, "_match"}, dut.match_q, 3'd0);
    chk({tag, "_cand"}, dut.cand_q, 64'h0);
    chk({tag, "_prev"}, dut.prev_q, 64'h0);
  endtask
  task automatic reset_dut(input string tag);
    rst_n = 1'b0;
    bus.i_enable = 1'b1;
    bus.i_frame_done = 1'b0;
    bus.i_sort_done = 1'b0;
    bus.i_sort_order = '0;
    bus.i_clr_err = 1'b0;
    #1;
    check_reset(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_frame();
    bus.i_frame_done = 1'b1;
    @(negedge clk);
    bus.i_frame_done = 1'b0;
    chk("sort_start", bus.o_sort_start, 1'b1);
    chk("busy_start", bus.o_busy, 1'b1);
  endtask
  task automatic answer(input logic [63:0] ord, input int dly);
    idle(dly);
    bus.i_sort_done = 1'b1;
    bus.i_sort_order = ord;
    @(negedge clk);
    bus.i_sort_done = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    reset_dut("por");
    start_frame(); answer(X, 20);
    chk("s1_match1", dut.match_q, 3'd1);
    chk("s1_stable1", bus.o_stable, 1'b0);
    start_frame(); answer(X, 20);
    chk("s1_match2", dut.match_q, 3'd2);
    chk("s1_nopub", bus.o_order, 64'h0);
    sb.push_back(X);
    start_frame(); answer(X, 20);
    chk("s1_match3", dut.match_q, 3'd3);
    @(negedge clk);
    chk("s1_pubs", pub_cnt, 1);
    chk("s1_sb_empty", sb.size(), 0);
    chk("s1_order", bus.o_order, X);
    chk("s1_stable", bus.o_stable, 1'b1);
    chk("s1_valid_low", bus.o_order_valid, 1'b0);
    start_frame(); idle(63);
    chk("to_not_yet", bus.o_timeout, 1'b0);
    chk("to_busy", bus.o_busy, 1'b1);
    idle(1);
    chk("to_set", bus.o_timeout, 1'b1);
    chk("to_idle", dut.state_q, 2'd0);
    chk("to_busy_low", bus.o_busy, 1'b0);
    chk("to_stable", bus.o_stable, 1'b0);
    chk("to_match", dut.match_q, 3'd0);
    bus.i_clr_err = 1'b1;
    @(negedge clk);
    bus.i_clr_err = 1'b0;
    chk("clr_err", bus.o_timeout, 1'b0);
    start_frame(); idle(63);
    bus.i_clr_err = 1'b1;
    @(negedge clk);
    bus.i_clr_err = 1'b0;
    chk("clr_vs_timeout", bus.o_timeout, 1'b1);
    reset_dut("rst2");
    p0 = pub_cnt;
    start_frame(); answer(A, 3);
    chk("s2_m1", dut.match_q, 3'd1);
    start_frame(); answer(A, 3);
    chk("s2_m2", dut.match_q, 3'd2);
    chk("s2_nopub_a", bus.o_order, 64'h0);
    start_frame(); answer(B, 3);
    chk("s2_m3", dut.match_q, 3'd1);
    start_frame();
    bus.i_enable = 1'b0;
    answer(B, 3);
    bus.i_enable = 1'b1;
    chk("s2_m4_disabled", dut.match_q, 3'd2);
    sb.push_back(B);
    start_frame(); answer(B, 3);
    chk("s2_m5", dut.match_q, 3'd3);
    @(negedge clk);
    chk("s2_pubs", pub_cnt - p0, 1);
    chk("s2_order", bus.o_order, B);
    chk("s2_stable", bus.o_stable, 1'b1);
    start_frame(); answer(B, 3);
    @(negedge clk);
    chk("s2_republish", pub_cnt - p0, 1);
    chk("s2_m6", dut.match_q, 3'd3);
    chk("s2_drop", bus.o_drop_cnt, 8'd0);
    reset_dut("rst3");
    start_frame();
    repeat (20) begin
      bus.i_frame_done = 1'b1; @(negedge clk);
      bus.i_frame_done = 1'b0; @(negedge clk);
    end
    chk("drop20", bus.o_drop_cnt, 8'd20);
    chk("drop_busy", bus.o_busy, 1'b1);
    bus.i_enable = 1'b0;
    repeat (280) begin
      bus.i_frame_done = 1'b1; @(negedge clk);
      bus.i_frame_done = 1'b0; @(negedge clk);
    end
    bus.i_enable = 1'b1;
    chk("drop_sat", bus.o_drop_cnt, 8'd255);
    reset_dut("rst4");
    start_frame(); idle(63);
    bus.i_sort_done = 1'b1;
    bus.i_sort_order = C;
    @(negedge clk);
    bus.i_sort_done = 1'b0;
    chk("race_timeout", bus.o_timeout, 1'b0);
    chk("race_cand", dut.cand_q, C);
    chk("race_check", dut.state_q, 2'd3);
    @(negedge clk);
    chk("race_timeout2", bus.o_timeout, 1'b0);
    chk("race_match", dut.match_q, 3'd1);
    reset_dut("rst5");
    start_frame(); idle(10);
    rst_n = 1'b0;
    #1;
    check_reset("mid_wait");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    bus.i_sort_done = 1'b1;
    bus.i_sort_order = D;
    @(negedge clk);
    bus.i_sort_done = 1'b0;
    idle(3);
    check_reset("late_done");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
